pipe_stage_buffer: RTL



---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_payload_reg.sv | 32 +++
 rtl/pipe_stage_buffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage buffer: state encoding,
// NOP fill value and default geometry of the fetch/decode instance.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t EMPTY = 2'd0;
    localparam state_t ONE   = 2'd1;
    localparam state_t FULL  = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LANES = 3;

endpackage

// File: rtl/pipe_payload_reg.sv
// Opaque payload register with load and clear-to-NOP; clear wins over load.
module pipe_payload_reg
    import pipe_pkg::*;
#(
    parameter int W = DEF_WIDTH * DEF_LANES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Payload storage: clear fills with NOP, load captures, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {W{NOP_WORD[0]}};
        end else if (clear) begin
            q_r <= {W{NOP_WORD[0]}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush,
// optional clear-to-NOP on empty and a saturating stall-cycle counter.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int LANES          = DEF_LANES,
    parameter bit CLEAR_ON_EMPTY = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   flush,
    output logic [CNT_W-1:0]       stall_cnt,
    input  logic                   clr_cnt
);

    localparam int DW = LANES * WIDTH;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             push_s;
    logic             pop_s;
    logic             main_load_s;
    logic             main_clr_s;
    logic             skid_load_s;
    logic             skid_clr_s;
    logic [DW-1:0]    main_d_s;
    logic [DW-1:0]    main_q_s;
    logic [DW-1:0]    skid_q_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Next-state and payload steering; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        main_load_s = 1'b0;
        main_clr_s  = 1'b0;
        skid_load_s = 1'b0;
        skid_clr_s  = 1'b0;
        main_d_s    = in_data;
        if (flush) begin
            state_nxt_s = EMPTY;
            main_clr_s  = 1'b1;
            skid_clr_s  = 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = ONE;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = ONE;
                    end else if (push_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = FULL;
                    end else if (pop_s) begin
                        main_clr_s  = CLEAR_ON_EMPTY;
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    // The skid entry is older than anything upstream, so it moves up first.
                    if (pop_s) begin
                        main_d_s    = skid_q_s;
                        main_load_s = 1'b1;
                        skid_clr_s  = 1'b1;
                        state_nxt_s = ONE;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    main_clr_s  = 1'b1;
                    skid_clr_s  = 1'b1;
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State plus handshake flags registered from the next state, keeping out_ready off the in_ready path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            in_ready_r  <= (state_nxt_s != FULL);
        end
    end

    // Saturating count of stalled valid cycles; clearing wins over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    pipe_payload_reg #(.W(DW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load_s),
        .clear (main_clr_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    pipe_payload_reg #(.W(DW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load_s),
        .clear (skid_clr_s),
        .d     (in_data),
        .q     (skid_q_s)
    );

    assign out_data  = main_q_s;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign stall_cnt = stall_cnt_r;

endmodule
